// File: rtl/accumulation_drain_if.sv
// Writeback read port toward accumulation_buffer plus the valid/ready output stream.
// master = drain block, slave = buffer read side and downstream sink.
interface accumulation_drain_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 7
);
  logic                       ren_wb;
  logic [BANK_ADDR_WIDTH-1:0] radr_wb;
  logic [DATA_WIDTH-1:0]      rdata_wb;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_data;

  modport master (
    output ren_wb, radr_wb, out_valid, out_data,
    input  rdata_wb, out_ready
  );

  modport slave (
    input  ren_wb, radr_wb, out_valid, out_data,
    output rdata_wb, out_ready
  );
endinterface

// File: rtl/accumulation_drain.sv
// Drains one bank in address order onto a valid/ready stream; first word 2 cycles after first read, then 1/cycle.
// Backpressure: reads are issued only against free skid-FIFO credit, so stalls never drop or repeat a word.
module accumulation_drain #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH      = 128,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BANK_ADDR_WIDTH:0] num_words,
  output logic                     busy,
  output logic                     done,
  accumulation_drain_if.master     bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = BANK_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t                     state_q, state_d;
  logic [NW-1:0]              nwords_q, nwords_d;
  logic [NW-1:0]              issued_q, issued_d;
  logic [BANK_ADDR_WIDTH-1:0] radr_q, radr_d;
  logic                       inflight_q;
  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              count_q, count_d;
  logic [CW-1:0]              occ;
  logic [NW-1:0]              nw_clamped;
  logic                       ren, pop, push, fifo_vld, last_issue, accept;

  assign nw_clamped = (num_words > NW'(BANK_DEPTH)) ? NW'(BANK_DEPTH) : num_words;
  assign fifo_vld   = (count_q != '0);
  assign pop        = fifo_vld & bus.out_ready;
  assign push       = inflight_q;
  // Occupancy the FIFO will have after this cycle's pop, counting the read already in flight.
  assign occ        = count_q + CW'(inflight_q) - CW'(pop);
  assign last_issue = ren && ((issued_q + NW'(1)) == nwords_q);
  assign accept     = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (nw_clamped == '0) ? DONE : DRAIN;
      DRAIN:   if (last_issue) state_d = FLUSH;
      FLUSH:   if ((count_q == '0) && !inflight_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ren  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      DRAIN: begin
        ren  = (issued_q < nwords_q) && (occ < CW'(FIFO_DEPTH));
        busy = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nwords_d = nwords_q;
    issued_d = issued_q;
    radr_d   = radr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (accept) begin
      nwords_d = nw_clamped;
      issued_d = '0;
      radr_d   = '0;
    end else if (ren) begin
      issued_d = issued_q + NW'(1);
      radr_d   = radr_q + BANK_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nwords_q   <= '0;
      issued_q   <= '0;
      radr_q     <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      nwords_q   <= nwords_d;
      issued_q   <= issued_d;
      radr_q     <= radr_d;
      inflight_q <= ren;
      count_q    <= count_d;
      if (push) begin
        mem_q[wptr_q] <= bus.rdata_wb;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign bus.ren_wb    = ren;
  assign bus.radr_wb   = radr_q;
  assign bus.out_valid = fifo_vld;
  assign bus.out_data  = fifo_vld ? mem_q[rptr_q] : '0;
endmodule

// File: tb/tb_accumulation_drain.sv
// Directed bench for accumulation_drain: bank read model, stream monitor, hand-computed expectations.
module tb_accumulation_drain;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int FD = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;

  accumulation_drain_if #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) bus_if ();

  accumulation_drain #(
    .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(128), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .busy(busy), .done(done), .bus(bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] bank [128];
  always @(posedge clk) if (bus_if.ren_wb) bus_if.rdata_wb <= bank[bus_if.radr_wb];

  // Ready driver: level mode or the 1,0,0,1 toggle pattern.
  logic tog_en;
  logic rdy_lvl;
  int   tog_ph;
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      bus_if.out_ready = (tog_ph == 0) || (tog_ph == 3);
      tog_ph = (tog_ph + 1) % 4;
    end else begin
      bus_if.out_ready = rdy_lvl;
      tog_ph = 0;
    end
  end

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Stream / read-port monitor, sampled on the falling edge.
  logic [DW-1:0] got[$];
  int            pop_cyc[$];
  logic [AW-1:0] ren_addr[$];
  int            ren_cyc[$];
  int done_cnt, vld_cnt, stall_err, credit_viol, outstanding;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  initial begin
    done_cnt = 0; vld_cnt = 0; stall_err = 0; credit_viol = 0; outstanding = 0;
    prev_stall = 1'b0; prev_data = '0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall && (!bus_if.out_valid || bus_if.out_data != prev_data)) stall_err++;
      if (bus_if.out_valid) vld_cnt++;
      if (done) done_cnt++;
      if (bus_if.ren_wb) begin
        ren_addr.push_back(bus_if.radr_wb);
        ren_cyc.push_back(cyc);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        got.push_back(bus_if.out_data);
        pop_cyc.push_back(cyc);
      end
      outstanding = outstanding + int'(bus_if.ren_wb) - int'(bus_if.out_valid && bus_if.out_ready);
      if (outstanding > FD) credit_viol++;
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
    end
  end

  int n_total, n_pass;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go(input logic [AW:0] nw);
    @(posedge clk); #1;
    num_words = nw;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, DW'(seen), DW'(1));
    repeat (2) @(negedge clk);
  endtask

  int b_got, b_ren, b_done, b_vld, b_stall, b_cred;
  task automatic snap();
    b_got = got.size(); b_ren = ren_addr.size(); b_done = done_cnt;
    b_vld = vld_cnt; b_stall = stall_err; b_cred = credit_viol;
  endtask

  // Compares n accepted words and n read addresses (0..n-1) against the bank contents.
  task automatic check_drain(input string tag, input int n);
    int derr, aerr;
    derr = 0; aerr = 0;
    check({tag, "_words"}, DW'(got.size() - b_got), DW'(n));
    check({tag, "_reads"}, DW'(ren_addr.size() - b_ren), DW'(n));
    for (int i = 0; i < n && (b_got + i) < got.size(); i++)
      if (got[b_got + i] !== bank[i]) derr++;
    for (int i = 0; i < n && (b_ren + i) < ren_addr.size(); i++)
      if (ren_addr[b_ren + i] !== AW'(i)) aerr++;
    check({tag, "_data_err"}, DW'(derr), DW'(0));
    check({tag, "_addr_err"}, DW'(aerr), DW'(0));
    check({tag, "_done_pulses"}, DW'(done_cnt - b_done), DW'(1));
    check({tag, "_busy_low"}, DW'(busy), DW'(0));
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    tog_en = 1'b0; rdy_lvl = 1'b1;
    rst_n = 1'b0; start = 1'b0; num_words = '0;
    for (int i = 0; i < 128; i++) bank[i] = DW'(i * 'h10);

    // Reset held 4 cycles with a start pulse that must be ignored.
    repeat (2) @(posedge clk);
    #1 start = 1'b1; num_words = 8'd16;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ren", DW'(bus_if.ren_wb), DW'(0));
    check("rst_radr", DW'(bus_if.radr_wb), DW'(0));
    check("rst_valid", DW'(bus_if.out_valid), DW'(0));
    check("rst_data", bus_if.out_data, DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    repeat (3) @(negedge clk);
    check("rst_start_ignored", DW'(ren_addr.size()), DW'(0));

    // 16 words, ready held high: back-to-back reads and pops.
    snap();
    go(8'd16);
    wait_done("t2_done", 100);
    check_drain("t2", 16);
    if (ren_cyc.size() >= b_ren + 16)
      check("t2_ren_span", DW'(ren_cyc[b_ren + 15] - ren_cyc[b_ren]), DW'(15));
    else check("t2_ren_span", DW'(ren_cyc.size() - b_ren), DW'(16));
    if (pop_cyc.size() >= b_got + 16) begin
      check("t2_pop_span", DW'(pop_cyc[b_got + 15] - pop_cyc[b_got]), DW'(15));
      check("t2_first_latency", DW'(pop_cyc[b_got] - ren_cyc[b_ren]), DW'(2));
    end else check("t2_pop_span", DW'(pop_cyc.size() - b_got), DW'(16));

    // 16 words under a 1,0,0,1 ready pattern.
    snap();
    tog_en = 1'b1;
    go(8'd16);
    wait_done("t3_done", 200);
    tog_en = 1'b0;
    check_drain("t3", 16);
    check("t3_stall_err", DW'(stall_err - b_stall), DW'(0));
    check("t3_credit_viol", DW'(credit_viol - b_cred), DW'(0));

    // num_words = 0: done visible the cycle after start is sampled, no traffic.
    snap();
    go(8'd0);
    @(negedge clk);
    check("t4_nw0_done", DW'(done), DW'(1));
    @(negedge clk);
    check("t4_nw0_done_pulse", DW'(done), DW'(0));
    check("t4_nw0_reads", DW'(ren_addr.size() - b_ren), DW'(0));
    check("t4_nw0_valid", DW'(vld_cnt - b_vld), DW'(0));

    // Full bank.
    for (int i = 0; i < 128; i++) bank[i] = DW'(32'hDEADBEEF + i);
    snap();
    go(8'd128);
    wait_done("t4_full_done", 400);
    check_drain("t4_full", 128);
    if (ren_addr.size() > 0) check("t4_last_radr", DW'(ren_addr[$]), DW'(127));
    check("t4_credit_viol", DW'(credit_viol - b_cred), DW'(0));

    // Oversized num_words clamps to one bank.
    snap();
    go(8'd200);
    wait_done("t4_clamp_done", 400);
    check("t4_clamp_reads", DW'(ren_addr.size() - b_ren), DW'(128));

    // Second start mid-drain must be ignored.
    for (int i = 0; i < 128; i++) bank[i] = DW'(i * 'h10);
    snap();
    go(8'd16);
    repeat (5) @(posedge clk);
    #1 num_words = 8'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5_done", 100);
    repeat (4) @(negedge clk);
    check_drain("t5", 16);

    // Reset after 5 accepted words, then a fresh 3-word drain.
    snap();
    go(8'd16);
    for (int i = 0; i < 50 && (got.size() - b_got) < 5; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_words_before_rst", DW'(got.size() - b_got), DW'(5));
    check("t6_valid_after_rst", DW'(bus_if.out_valid), DW'(0));
    check("t6_busy_after_rst", DW'(busy), DW'(0));
    check("t6_ren_after_rst", DW'(bus_if.ren_wb), DW'(0));
    snap();
    go(8'd3);
    wait_done("t6_done", 50);
    check_drain("t6", 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
